// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: unit latencies,
// mult/div sequencer state encoding and the register-zero constant.
package hazard_ctrl_pkg;

    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX status in, pipeline enables/flushes and mult/div sequencing out.
interface hazard_ctrl_if;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UseRs;
    logic        ID_UseRt;
    logic        ID_Jump;
    logic        ID_MulDiv;
    logic        ID_IsDiv;
    logic        ID_UseHiLo;
    logic        EX_MemRead;
    logic [4:0]  EX_Rd;
    logic        EX_BranchTaken;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        MD_Start;
    logic        MD_Busy;
    logic [31:0] StallCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Jump, ID_MulDiv,
               ID_IsDiv, ID_UseHiLo, EX_MemRead, EX_Rd, EX_BranchTaken,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
               MD_Start, MD_Busy, StallCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Jump, ID_MulDiv,
               ID_IsDiv, ID_UseHiLo, EX_MemRead, EX_Rd, EX_BranchTaken,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
               MD_Start, MD_Busy, StallCount
    );
endinterface

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Mult/div busy sequencer: an issue pulse loads the unit latency and the
// unit reads as busy for exactly that many cycles afterwards.
module muldiv_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    md_state_t  state;
    logic [5:0] cnt;

    // IDLE->BUSY on issue, count down, drop back to IDLE on the Cnt==1 edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= is_div ? 6'(DIV_LAT) : 6'(MULT_LAT);
                    end
                end
                BUSY: begin
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 6'd0;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller beside ID: load-use and HI/LO stalls, jump
// bubbles, branch flushes, mult/div issue and a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    logic lu, mh, stall, md_start, md_busy;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic [31:0] stall_count;

    // Load-use: EX load target matches a register ID actually reads ($0 exempt)
    always_comb begin
        lu = bus.EX_MemRead && (bus.EX_Rd != REG_ZERO) &&
             ((bus.ID_UseRs && (bus.ID_Rs == bus.EX_Rd)) ||
              (bus.ID_UseRt && (bus.ID_Rt == bus.EX_Rd)));
        mh    = md_busy && (bus.ID_UseHiLo || bus.ID_MulDiv);
        stall = lu || mh;
    end

    // A wrong-path instruction in ID must never issue to the mult/div unit
    assign md_start = bus.ID_MulDiv && !stall && !bus.EX_BranchTaken;

    // Priority mux: branch flush, then stall, then jump bubble, then run
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (bus.EX_BranchTaken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (bus.ID_Jump) begin
            if_id_flush = 1'b1;
        end
    end

    // Count frozen-PC cycles, sticking at all ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= 32'd0;
        else if (!pc_write && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end

    muldiv_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (bus.ID_IsDiv),
        .busy   (md_busy)
    );

    assign bus.PC_Write    = pc_write;
    assign bus.IF_ID_Write = if_id_write;
    assign bus.IF_ID_Flush = if_id_flush;
    assign bus.ID_EX_Flush = id_ex_flush;
    assign bus.MD_Start    = md_start;
    assign bus.MD_Busy     = md_busy;
    assign bus.StallCount  = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a behavioural model pushes expected outputs into a
// scoreboard each cycle; they are popped and compared against the DUT.
module tb_hazard_ctrl;

    localparam int MLAT = 4;
    localparam int DLAT = 32;

    typedef struct {
        logic        pc_write;
        logic        if_id_write;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic        md_start;
        logic        md_busy;
        logic [31:0] stall_count;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    hazard_ctrl_if hif();

    hazard_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    int          m_cnt = 0;
    logic [31:0] m_stall = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        hif.ID_Rs = 5'd0; hif.ID_Rt = 5'd0;
        hif.ID_UseRs = 1'b0; hif.ID_UseRt = 1'b0;
        hif.ID_Jump = 1'b0; hif.ID_MulDiv = 1'b0; hif.ID_IsDiv = 1'b0;
        hif.ID_UseHiLo = 1'b0; hif.EX_MemRead = 1'b0; hif.EX_Rd = 5'd0;
        hif.EX_BranchTaken = 1'b0;
    endtask

    // Model of the expected outputs from the current inputs and model state
    function automatic exp_t model();
        exp_t e;
        logic lu, mh, s, busy;
        busy = (m_cnt > 0);
        lu = hif.EX_MemRead && (hif.EX_Rd != 5'd0) &&
             ((hif.ID_UseRs && hif.ID_Rs == hif.EX_Rd) ||
              (hif.ID_UseRt && hif.ID_Rt == hif.EX_Rd));
        mh = busy && (hif.ID_UseHiLo || hif.ID_MulDiv);
        s  = lu || mh;
        e.md_busy     = busy;
        e.stall_count = m_stall;
        e.md_start    = hif.ID_MulDiv && !s && !hif.EX_BranchTaken;
        if (hif.EX_BranchTaken) begin
            e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_flush = 1;
        end else if (s) begin
            e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 0; e.id_ex_flush = 1;
        end else if (hif.ID_Jump) begin
            e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_flush = 0;
        end else begin
            e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 0; e.id_ex_flush = 0;
        end
        return e;
    endfunction

    // One cycle: inputs already driven just after posedge. Push, compare, advance.
    task automatic step(output exp_t got_e);
        exp_t e, x;
        logic is_div;
        e = model();
        is_div = hif.ID_IsDiv;
        sb.push_back(e);
        #2;
        x = sb.pop_front();
        chk("pc_write",    {31'd0, hif.PC_Write},    {31'd0, x.pc_write});
        chk("if_id_write", {31'd0, hif.IF_ID_Write}, {31'd0, x.if_id_write});
        chk("if_id_flush", {31'd0, hif.IF_ID_Flush}, {31'd0, x.if_id_flush});
        chk("id_ex_flush", {31'd0, hif.ID_EX_Flush}, {31'd0, x.id_ex_flush});
        chk("md_start",    {31'd0, hif.MD_Start},    {31'd0, x.md_start});
        chk("md_busy",     {31'd0, hif.MD_Busy},     {31'd0, x.md_busy});
        chk("stall_count", hif.StallCount,           x.stall_count);
        got_e.pc_write    = hif.PC_Write;
        got_e.if_id_write = hif.IF_ID_Write;
        got_e.if_id_flush = hif.IF_ID_Flush;
        got_e.id_ex_flush = hif.ID_EX_Flush;
        got_e.md_start    = hif.MD_Start;
        got_e.md_busy     = hif.MD_Busy;
        got_e.stall_count = hif.StallCount;
        @(posedge clk);
        if (!x.pc_write && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (x.md_start) m_cnt = is_div ? DLAT : MLAT;
        else if (m_cnt > 0) m_cnt--;
        #1;
    endtask

    // Hold a HI/LO reader in ID until it proceeds; returns stall cycles seen
    task automatic hilo_wait(output int n);
        exp_t g;
        n = 0;
        idle_in();
        hif.ID_UseHiLo = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step(g);
            if (g.pc_write) break;
            n++;
        end
        idle_in();
    endtask

    initial begin
        exp_t g;
        int n;
        logic [31:0] sc0;
        idle_in();
        #1;
        chk("rst_busy",  {31'd0, hif.MD_Busy}, 32'd0);
        chk("rst_stall", hif.StallCount, 32'd0);
        chk("rst_pcw",   {31'd0, hif.PC_Write}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // load-use on Rs
        hif.EX_MemRead = 1; hif.EX_Rd = 5'd8; hif.ID_Rs = 5'd8; hif.ID_UseRs = 1;
        step(g);
        chk("lu_pcw0", {31'd0, g.pc_write}, 32'd0);
        chk("lu_flush", {31'd0, g.id_ex_flush}, 32'd1);
        idle_in();
        step(g);
        chk("lu_release", {31'd0, g.pc_write}, 32'd1);
        chk("lu_count", g.stall_count, 32'd1);

        // load-use on Rt, and Rt match without UseRt
        hif.EX_MemRead = 1; hif.EX_Rd = 5'd9; hif.ID_Rt = 5'd9; hif.ID_UseRt = 1;
        step(g);
        chk("lu_rt", {31'd0, g.pc_write}, 32'd0);
        hif.ID_UseRt = 0;
        step(g);
        chk("lu_rt_unused", {31'd0, g.pc_write}, 32'd1);

        // load into $0 never stalls
        idle_in();
        hif.EX_MemRead = 1; hif.EX_Rd = 5'd0; hif.ID_Rs = 5'd0; hif.ID_UseRs = 1;
        hif.ID_Rt = 5'd0; hif.ID_UseRt = 1;
        step(g);
        chk("lu_zero", {31'd0, g.pc_write}, 32'd1);

        // div then mfhi
        idle_in();
        hif.ID_MulDiv = 1; hif.ID_IsDiv = 1;
        step(g);
        chk("div_start", {31'd0, g.md_start}, 32'd1);
        sc0 = hif.StallCount;
        hilo_wait(n);
        chk("div_stalls", n, DLAT);
        chk("div_busy_fall", {31'd0, hif.MD_Busy}, 32'd0);
        chk("div_count", hif.StallCount - sc0, DLAT);

        // back-to-back mult
        hif.ID_MulDiv = 1; hif.ID_IsDiv = 0;
        step(g);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(g);
            if (g.md_start) break;
            n++;
        end
        chk("mult_b2b_stalls", n, MLAT);
        idle_in();

        // branch beats load-use and mult/div issue (unit is busy here)
        hif.EX_BranchTaken = 1; hif.EX_MemRead = 1; hif.EX_Rd = 5'd3;
        hif.ID_Rs = 5'd3; hif.ID_UseRs = 1; hif.ID_MulDiv = 1;
        step(g);
        chk("br_pcw", {31'd0, g.pc_write}, 32'd1);
        chk("br_ifid", {31'd0, g.if_id_flush}, 32'd1);
        chk("br_idex", {31'd0, g.id_ex_flush}, 32'd1);
        chk("br_mds", {31'd0, g.md_start}, 32'd0);
        idle_in();
        for (int i = 0; i < 6; i++) step(g);

        // jump
        hif.ID_Jump = 1;
        step(g);
        chk("jmp_ifid", {31'd0, g.if_id_flush}, 32'd1);
        chk("jmp_idex", {31'd0, g.id_ex_flush}, 32'd0);
        idle_in();
        step(g);
        chk("jmp_once", {31'd0, g.if_id_flush}, 32'd0);

        // reset in the middle of a mult
        hif.ID_MulDiv = 1; hif.ID_IsDiv = 0;
        step(g);
        idle_in();
        step(g); step(g);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, hif.MD_Busy}, 32'd0);
        chk("mid_rst_stall", hif.StallCount, 32'd0);
        m_cnt = 0; m_stall = 32'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        hif.ID_MulDiv = 1; hif.ID_IsDiv = 0;
        step(g);
        chk("post_rst_start", {31'd0, g.md_start}, 32'd1);
        hilo_wait(n);
        chk("post_rst_lat", n, MLAT);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            hif.ID_Rs = 5'($urandom_range(0, 3));
            hif.ID_Rt = 5'($urandom_range(0, 3));
            hif.EX_Rd = 5'($urandom_range(0, 3));
            hif.ID_UseRs = 1'($urandom);
            hif.ID_UseRt = 1'($urandom);
            hif.EX_MemRead = 1'($urandom);
            hif.ID_Jump = ($urandom_range(0, 7) == 0);
            hif.ID_MulDiv = ($urandom_range(0, 5) == 0);
            hif.ID_IsDiv = ($urandom_range(0, 3) == 0);
            hif.ID_UseHiLo = ($urandom_range(0, 3) == 0);
            hif.EX_BranchTaken = ($urandom_range(0, 7) == 0);
            step(g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
